sam_scandoubler: RTL and testbench

Video back-end stage downstream of the SAM ASIC video outputs (r, g, b, bright, csync). Separates composite sync into line and frame events, stores each 15 kHz input line in a ping-pong line buffer and replays every stored line twice at double rate, producing 31 kHz RGBI with separate active-low hsync/vsync for a VGA monitor. Sits between the ASIC video port and the board's video DAC pins.

---
 rtl/sam_scandoubler_pkg.sv | 28 ++
 rtl/sam_scandoubler_linebuf_dp.sv | 28 ++
 rtl/sam_scandoubler.sv | 178 +++++++++++++++++
 tb/tb_sam_scandoubler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_scandoubler_pkg.sv
// Shared types for the SAM 15 kHz -> 31 kHz scandoubler.
// Pixel packing is {r[1:0], g[1:0], b[1:0], bright}.
package sam_scandoubler_pkg;

  localparam int PIX_W      = 7;
  localparam int PIX_BRIGHT = 0;
  localparam int PIX_B      = 1;
  localparam int PIX_G      = 3;
  localparam int PIX_R      = 5;

  typedef logic [PIX_W-1:0] pix_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS0,
    PASS1
  } state_e;

  function automatic pix_t pack_pix(
    input logic [1:0] r,
    input logic [1:0] g,
    input logic [1:0] b,
    input logic       br
  );
    return {r, g, b, br};
  endfunction

endpackage

// File: rtl/sam_scandoubler_linebuf_dp.sv
// Ping-pong line store: two banks of DEPTH pixels, one write
// port and one registered read port on the same clock.
module sam_scandoubler_linebuf_dp
  import sam_scandoubler_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          wbank_i,
  input  logic [AW-1:0] waddr_i,
  input  pix_t          wdata_i,
  input  logic          rbank_i,
  input  logic [AW-1:0] raddr_i,
  output pix_t          rdata_o
);

  pix_t mem_q [2*DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
    rdata_o <= mem_q[{rbank_i, raddr_i}];
  end

endmodule

// File: rtl/sam_scandoubler.sv
// Sync separator, line capture and double-rate replay of each
// SAM input line as two VGA lines with separate h/v sync.
module sam_scandoubler
  import sam_scandoubler_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int HS_OUT = 92,
  parameter int VS_MIN = 120,
  parameter int L_MIN  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_in,
  input  logic [1:0] r_in,
  input  logic [1:0] g_in,
  input  logic [1:0] b_in,
  input  logic       bright_in,
  input  logic       csync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       bright_out,
  output logic       hsync_n,
  output logic       vsync_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int VW = $clog2(VS_MIN + 1);

  typedef logic [LW-1:0] len_t;

  pix_t          pix_q;
  logic          csync_q;
  logic          csync_p_q;
  logic [VW-1:0] low_q;
  logic          vs_flag_q;
  len_t          cnt_q;
  len_t          len_q;
  logic          wbank_q;
  logic [1:0]    seen_q;

  state_e        state_q;
  len_t          pos_q;
  logic          rbank_q;
  logic          vs_pass_q;

  logic          act1_q;
  logic          hs1_q;
  logic          vs1_q;
  pix_t          opix_q;
  logic          hs_n_q;
  logic          vs_n_q;

  logic          line_start;
  logic          go;
  logic          pos_last;
  logic          wbank_d;
  logic [AW-1:0] waddr_d;
  pix_t          rdata;

  assign line_start = ce_in & ~csync_q & csync_p_q;
  assign go         = (seen_q != 2'd0) && (cnt_q >= LW'(L_MIN));
  assign pos_last   = (pos_q == len_q - LW'(1));
  assign wbank_d    = line_start ? ~wbank_q : wbank_q;

  // cnt_q saturates at DEPTH, so its top bit pins the last cell
  always_comb begin
    waddr_d = cnt_q[AW-1:0];
    if (cnt_q[AW]) waddr_d = '1;
    if (line_start) waddr_d = '0;
  end

  sam_scandoubler_linebuf_dp #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk     (clk),
    .we_i    (ce_in),
    .wbank_i (wbank_d),
    .waddr_i (waddr_d),
    .wdata_i (pix_q),
    .rbank_i (rbank_q),
    .raddr_i (pos_q[AW-1:0]),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q     <= '0;
      csync_q   <= 1'b1;
      csync_p_q <= 1'b1;
      low_q     <= '0;
      vs_flag_q <= 1'b0;
      cnt_q     <= '0;
      len_q     <= '0;
      wbank_q   <= 1'b0;
      seen_q    <= '0;
    end else if (ce_in) begin
      pix_q     <= pack_pix(r_in, g_in, b_in, bright_in);
      csync_q   <= csync_in;
      csync_p_q <= csync_q;
      if (!csync_q) begin
        if (low_q != VW'(VS_MIN)) low_q <= low_q + VW'(1);
      end else begin
        low_q <= '0;
        if (!csync_p_q) vs_flag_q <= (low_q == VW'(VS_MIN));
      end
      if (line_start) begin
        len_q   <= cnt_q;
        cnt_q   <= LW'(1);
        wbank_q <= ~wbank_q;
        if (seen_q != 2'd2) seen_q <= seen_q + 2'd1;
      end else if (!cnt_q[AW]) begin
        cnt_q <= cnt_q + LW'(1);
      end
    end
  end

  // a new input line always wins over the end of a pass
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pos_q     <= '0;
      rbank_q   <= 1'b0;
      vs_pass_q <= 1'b0;
    end else if (line_start) begin
      rbank_q <= wbank_q;
      pos_q   <= '0;
      if (go) begin
        state_q   <= PASS0;
        vs_pass_q <= vs_flag_q;
      end else begin
        state_q <= IDLE;
      end
    end else begin
      unique case (state_q)
        PASS0: begin
          pos_q <= pos_last ? '0 : pos_q + LW'(1);
          if (pos_last) begin
            state_q   <= PASS1;
            vs_pass_q <= vs_flag_q;
          end
        end
        PASS1: begin
          pos_q <= pos_last ? '0 : pos_q + LW'(1);
          if (pos_last) state_q <= IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      opix_q <= '0;
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
    end else begin
      act1_q <= (state_q != IDLE);
      hs1_q  <= (pos_q < LW'(HS_OUT));
      vs1_q  <= vs_pass_q;
      opix_q <= (act1_q && !hs1_q) ? rdata : '0;
      hs_n_q <= ~(act1_q && hs1_q);
      vs_n_q <= ~vs1_q;
    end
  end

  assign r_out      = opix_q[PIX_R +: 2];
  assign g_out      = opix_q[PIX_G +: 2];
  assign b_out      = opix_q[PIX_B +: 2];
  assign bright_out = opix_q[PIX_BRIGHT];
  assign hsync_n    = hs_n_q;
  assign vsync_n    = vs_n_q;

endmodule

// File: tb/tb_sam_scandoubler.sv
// Bench for sam_scandoubler: line-level reference model plus
// hand-computed spot values at pass boundaries.
module tb_sam_scandoubler;

  localparam int DEPTH  = 1024;
  localparam int HS_OUT = 92;
  localparam int VS_MIN = 120;
  localparam int L_MIN  = 200;
  localparam int MAXC   = 32768;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ce_in = 1'b0;
  logic [1:0] r_in = '0;
  logic [1:0] g_in = '0;
  logic [1:0] b_in = '0;
  logic       bright_in = 1'b0;
  logic       csync_in = 1'b1;
  logic [1:0] r_out;
  logic [1:0] g_out;
  logic [1:0] b_out;
  logic       bright_out;
  logic       hsync_n;
  logic       vsync_n;

  always #5 clk = ~clk;

  sam_scandoubler #(
    .DEPTH(DEPTH), .HS_OUT(HS_OUT), .VS_MIN(VS_MIN), .L_MIN(L_MIN)
  ) dut (
    .clk(clk), .rst(rst), .ce_in(ce_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .bright_in(bright_in), .csync_in(csync_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .bright_out(bright_out), .hsync_n(hsync_n), .vsync_n(vsync_n)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [6:0] e_pix [MAXC];
  bit         e_hs  [MAXC];
  bit         e_vs  [MAXC];
  logic [6:0] a_pix [MAXC];
  logic       a_hs  [MAXC];
  logic       a_vs  [MAXC];

  logic [6:0] cur_line [2048];
  logic [6:0] fin_line [2048];
  int cur_n = 0;
  int fin_n = 0;
  int ls_cnt = 0;
  bit vs_cur = 1'b0;
  int r_edge = 0;

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  // Expected outputs from a line start registered on edge n_edge:
  // visible from n_edge+2, two passes of L, then black.
  task automatic model_ls(input int n_edge, input int w);
    logic [6:0] mem [DEPTH];
    int  len;
    int  c;
    int  pos;
    bit  vs0;
    bit  vs1;
    bit  v;
    ls_cnt++;
    len = (fin_n < DEPTH) ? fin_n : DEPTH;
    vs0 = vs_cur;
    vs1 = (2 * w <= len - 1) ? (w >= VS_MIN) : vs_cur;
    vs_cur = (w >= VS_MIN);
    if (ls_cnt >= 2 && len >= L_MIN) begin
      for (int a = 0; a < len; a++) mem[a] = fin_line[a];
      if (fin_n > DEPTH) mem[DEPTH-1] = fin_line[fin_n-1];
      for (int t = n_edge + 2; t < MAXC; t++) begin
        c = t - n_edge - 2;
        if (c < 2 * len) begin
          pos = c % len;
          e_hs[t]  = !(pos < HS_OUT);
          e_pix[t] = (pos < HS_OUT) ? 7'd0 : mem[pos];
          e_vs[t]  = (c < len) ? !vs0 : !vs1;
        end else begin
          e_hs[t]  = 1'b1;
          e_pix[t] = 7'd0;
          e_vs[t]  = !vs1;
        end
      end
    end else begin
      v = e_vs[n_edge+1];
      for (int t = n_edge + 2; t < MAXC; t++) begin
        e_hs[t]  = 1'b1;
        e_pix[t] = 7'd0;
        e_vs[t]  = v;
      end
    end
  endtask

  task automatic model_rst(input int edge_i);
    ls_cnt = 0;
    vs_cur = 1'b0;
    for (int t = edge_i; t < MAXC; t++) begin
      e_hs[t]  = 1'b1;
      e_pix[t] = 7'd0;
      e_vs[t]  = 1'b1;
    end
  endtask

  task automatic run_line(
    input  int ntot,
    input  int w,
    input  int seed,
    input  int rst_at,
    output int n_edge
  );
    logic [6:0] p;
    fin_n = cur_n;
    for (int i = 0; i < cur_n; i++) fin_line[i] = cur_line[i];
    cur_n  = 0;
    n_edge = 0;
    for (int n = 0; n < ntot; n++) begin
      p = 7'((n + seed) & 127);
      @(negedge clk);
      ce_in = 1'b1;
      {r_in, g_in, b_in, bright_in} = p;
      csync_in = (n < w) ? 1'b0 : 1'b1;
      cur_line[n] = p;
      cur_n = n + 1;
      if (n == 1) begin
        n_edge = cyc + 1;
        model_ls(n_edge, w);
      end
      if (n == rst_at) begin
        rst = 1'b1;
        r_edge = cyc + 1;
        model_rst(r_edge);
      end
      if (n == rst_at + 2) rst = 1'b0;
      @(negedge clk);
      ce_in = 1'b0;
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce_in = 1'b1;
      csync_in = 1'b1;
      {r_in, g_in, b_in, bright_in} = 7'd0;
      @(negedge clk);
      ce_in = 1'b0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!done && cyc >= 1 && cyc < MAXC) begin
      a_pix[cyc] = {r_out, g_out, b_out, bright_out};
      a_hs[cyc]  = hsync_n;
      a_vs[cyc]  = vsync_n;
      checks++;
      if ({r_out, g_out, b_out, bright_out} !== e_pix[cyc] ||
          hsync_n !== e_hs[cyc] || vsync_n !== e_vs[cyc]) begin
        errors++;
        $display("FAIL cycle %0d got pix=%h hs=%b vs=%b want pix=%h hs=%b vs=%b",
                 cyc, {r_out, g_out, b_out, bright_out}, hsync_n, vsync_n,
                 e_pix[cyc], e_hs[cyc], e_vs[cyc]);
      end
    end
  end

  int na, nb, nc, nd, ne, nf, ng, nh, ni, nj, nk, nl, nm, nn, no;

  initial begin
    for (int t = 0; t < MAXC; t++) begin
      e_pix[t] = 7'd0;
      e_hs[t]  = 1'b1;
      e_vs[t]  = 1'b1;
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle_ticks(10);
    run_line(768,  56,   0, -10, na);
    run_line(768,  56,   0, -10, nb);
    run_line(768,  56,   0, -10, nc);
    run_line(768,  330,  5, -10, nd);
    run_line(768,  56,   9, -10, ne);
    run_line(1100, 56,  17, -10, nf);
    run_line(1100, 56,  33, -10, ng);
    run_line(150,  56,  40, -10, nh);
    run_line(768,  56,  50, -10, ni);
    run_line(768,  56,  60, -10, nj);
    run_line(634,  56,  70, -10, nk);
    run_line(768,  56,  80, 300, nl);
    run_line(768,  56,  90, -10, nm);
    run_line(768,  56, 100, -10, nn);
    run_line(768,  56, 110, -10, no);
    idle_ticks(20);
    repeat (4) @(negedge clk);
    done = 1'b1;

    chk("reset_hs",      int'(a_hs[2]), 1);
    chk("reset_vs",      int'(a_vs[2]), 1);
    chk("first_ls_idle", int'(a_hs[nb]), 1);
    chk("hs_start",      int'(a_hs[nc+2]), 0);
    chk("hs_last_low",   int'(a_hs[nc+93]), 0);
    chk("hs_rise",       int'(a_hs[nc+94]), 1);
    chk("pix_blank",     int'(a_pix[nc+93]), 0);
    chk("pix92",         int'(a_pix[nc+94]), 92);
    chk("pix767",        int'(a_pix[nc+2+767]), 127);
    chk("pass1_hs",      int'(a_hs[nc+2+768]), 0);
    chk("pass1_pix200",  int'(a_pix[nc+2+968]), 72);
    chk("vs_pre_broad",  int'(a_vs[nd+2+767]), 1);
    chk("vs_broad",      int'(a_vs[nd+2+768]), 0);
    chk("vs_next0",      int'(a_vs[ne+2]), 0);
    chk("vs_back",       int'(a_vs[ne+2+768]), 1);
    chk("long_hs1023",   int'(a_hs[ng+2+1023]), 1);
    chk("long_pix1023",  int'(a_pix[ng+2+1023]), 92);
    chk("long_pix1022",  int'(a_pix[ng+2+1022]), 15);
    chk("long_pass1",    int'(a_hs[ng+2+1024]), 0);
    chk("long_idle",     int'(a_hs[ng+2+2048]), 1);
    chk("long_idle_pix", int'(a_pix[ng+2+2053]), 0);
    chk("short_hs",      int'(a_hs[ni+2]), 1);
    chk("short_pix",     int'(a_pix[ni+2+300]), 0);
    chk("short_hs_mid",  int'(a_hs[ni+2+500]), 1);
    chk("trunc_hs_pre",  int'(a_hs[nl+1]), 1);
    chk("trunc_pix_pre", int'(a_pix[nl+1]), 47);
    chk("trunc_restart", int'(a_hs[nl+2]), 0);
    chk("rst_edge_dist", r_edge - nl, 598);
    chk("rst_pre_pix",   int'(a_pix[r_edge-1]), 25);
    chk("rst_pix",       int'(a_pix[r_edge]), 0);
    chk("rst_hs",        int'(a_hs[r_edge]), 1);
    chk("rst_vs",        int'(a_vs[r_edge]), 1);
    chk("post_rst_ls1",  int'(a_hs[nm+2]), 1);
    chk("post_rst_ls2",  int'(a_hs[nn+2]), 0);
    chk("post_rst_pix",  int'(a_pix[nn+2+100]), 62);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
